// File: rtl/host_frame_tx.sv
// host_frame_tx: serialises 32-bit host words into toggle-synchronised byte frames for the CPU
// Ports:
//   sys_clk, sys_rst      clock and asynchronous active-low reset
//   word_in, word_valid   instruction word offered by the host (byte0 = word_in[7:0] sent first)
//   word_ready            high only while idle; a word is taken when valid and ready meet
//   ack_in                CPU sync output, asynchronous; an edge after the frame acknowledges it
//   sync_out, data_out    CPU sync/data inputs; every sync edge marks one byte
//   busy                  high while a frame or acknowledge wait is in progress
//   frame_done            one-cycle pulse on return to idle after an ack (or with no ack wait)
//   ack_timeout           one-cycle pulse on return to idle when no ack arrived in time
module host_frame_tx #(
    parameter int SLOT_CYC    = 4,
    parameter int SETUP_CYC   = 2,
    parameter int PRE_EDGES   = 3,
    parameter int WAIT_ACK    = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        ack_in,
    output logic        sync_out,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        frame_done,
    output logic        ack_timeout
);
    localparam int CW = $clog2(SLOT_CYC);
    localparam int IW = $clog2(PRE_EDGES + 5);

    typedef enum logic [2:0] {IDLE, PRE, DATA, CLOSE, ACK_WAIT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_nxt;
    logic [IW-1:0]   idx, idx_n;
    logic [15:0]     tmr, tmr_n;
    logic [31:0]     sr, sr_n;
    logic            ack_s1, ack_s2, ack_ref, ref_n;
    logic            sync_n, done_n, to_n, last;
    logic [7:0]      data_n;

    // cnt is the offset of the visible cycle within its slot; wrapping to 0 starts the next slot
    assign last    = (cnt == CW'(SLOT_CYC - 1));
    assign cnt_nxt = last ? '0 : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt_nxt;
        idx_n   = idx;
        tmr_n   = tmr;
        ref_n   = ack_ref;
        sr_n    = sr;
        sync_n  = sync_out;
        data_n  = data_out;
        done_n  = 1'b0;
        to_n    = 1'b0;
        // The close slot drives sync low instead of toggling, so it only makes an edge when sync is high
        if (state inside {PRE, DATA, CLOSE} && cnt_nxt == CW'(SETUP_CYC))
            sync_n = (state == CLOSE) ? 1'b0 : ~sync_out;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (word_valid && word_ready) begin
                    state_n = (PRE_EDGES == 0) ? DATA : PRE;
                    data_n  = (PRE_EDGES == 0) ? word_in[7:0] : 8'h00;
                    sr_n    = (PRE_EDGES == 0) ? {8'h00, word_in[31:8]} : word_in;
                end
            end
            PRE: begin
                if (last) begin
                    if (idx == IW'(PRE_EDGES - 1)) begin
                        state_n = DATA;
                        idx_n   = '0;
                        data_n  = sr[7:0];
                        sr_n    = {8'h00, sr[31:8]};
                    end else begin
                        idx_n  = idx + 1'b1;
                        data_n = 8'h00;
                    end
                end
            end
            DATA: begin
                if (last) begin
                    if (idx == IW'(3)) begin
                        state_n = CLOSE;
                        data_n  = 8'h00;
                    end else begin
                        idx_n  = idx + 1'b1;
                        data_n = sr[7:0];
                        sr_n   = {8'h00, sr[31:8]};
                    end
                end
            end
            CLOSE: begin
                if (last) begin
                    state_n = (WAIT_ACK != 0) ? ACK_WAIT : IDLE;
                    done_n  = (WAIT_ACK == 0);
                    tmr_n   = '0;
                    // Capturing the level here makes ack edges that happened during the frame harmless
                    ref_n   = ack_s2;
                end
            end
            ACK_WAIT: begin
                cnt_n = '0;
                if (ack_s2 != ack_ref) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tmr == 16'(ACK_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end else begin
                    tmr_n = tmr + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            tmr         <= '0;
            sr          <= '0;
            ack_s1      <= 1'b0;
            ack_s2      <= 1'b0;
            ack_ref     <= 1'b0;
            sync_out    <= 1'b0;
            data_out    <= 8'h00;
            busy        <= 1'b0;
            word_ready  <= 1'b0;
            frame_done  <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            tmr         <= tmr_n;
            sr          <= sr_n;
            ack_s1      <= ack_in;
            ack_s2      <= ack_s1;
            ack_ref     <= ref_n;
            sync_out    <= sync_n;
            data_out    <= data_n;
            busy        <= (state_n != IDLE);
            word_ready  <= (state_n == IDLE);
            frame_done  <= done_n;
            ack_timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_host_frame_tx.sv
// tb_host_frame_tx: randomized self-checking bench for host_frame_tx against a slot-arithmetic model
// Instances: 0 = defaults without ack wait, 1 = ack wait with ACK_TIMEOUT=20, 2 = PRE_EDGES=0, SLOT_CYC=2, SETUP_CYC=1
module tb_host_frame_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wi [3];
    logic        wv [3];
    logic        rdy [3];
    logic        ack [3];
    logic        sy [3];
    logic [7:0]  dat [3];
    logic        bsy [3];
    logic        dn [3];
    logic        to [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    host_frame_tx #(.WAIT_ACK(0)) u_a (
        .sys_clk(clk), .sys_rst(rst), .word_in(wi[0]), .word_valid(wv[0]), .word_ready(rdy[0]),
        .ack_in(ack[0]), .sync_out(sy[0]), .data_out(dat[0]), .busy(bsy[0]),
        .frame_done(dn[0]), .ack_timeout(to[0]));

    host_frame_tx #(.WAIT_ACK(1), .ACK_TIMEOUT(20)) u_b (
        .sys_clk(clk), .sys_rst(rst), .word_in(wi[1]), .word_valid(wv[1]), .word_ready(rdy[1]),
        .ack_in(ack[1]), .sync_out(sy[1]), .data_out(dat[1]), .busy(bsy[1]),
        .frame_done(dn[1]), .ack_timeout(to[1]));

    host_frame_tx #(.PRE_EDGES(0), .SLOT_CYC(2), .SETUP_CYC(1), .WAIT_ACK(0)) u_c (
        .sys_clk(clk), .sys_rst(rst), .word_in(wi[2]), .word_valid(wv[2]), .word_ready(rdy[2]),
        .ack_in(ack[2]), .sync_out(sy[2]), .data_out(dat[2]), .busy(bsy[2]),
        .frame_done(dn[2]), .ack_timeout(to[2]));

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int setup_of(int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int pre_of(int i);
        return (i == 2) ? 0 : 3;
    endfunction

    function automatic int flen(int i);
        return 1 + (pre_of(i) + 5) * slot_of(i);
    endfunction

    // Sync level in cycle t after the accept edge: one toggle per preamble/data slot once its setup
    // time has passed; the close slot forces the line low at its setup point
    function automatic logic m_sync(int i, int t);
        int s, off, p;
        if (t < 1) return 1'b0;
        s = (t - 1) / slot_of(i);
        off = (t - 1) % slot_of(i);
        p = pre_of(i);
        if (s > p + 4) return 1'b0;
        if (s == p + 4) return (off >= setup_of(i)) ? 1'b0 : 1'((p + 4) % 2);
        return 1'((s + ((off >= setup_of(i)) ? 1 : 0)) % 2);
    endfunction

    function automatic logic [7:0] m_data(int i, int t, logic [31:0] w);
        int s, p;
        if (t < 1) return 8'h00;
        s = (t - 1) / slot_of(i);
        p = pre_of(i);
        if (s < p || s >= p + 4) return 8'h00;
        return 8'(w >> (8 * (s - p)));
    endfunction

    // Offer w, then follow the whole frame cycle by cycle up to the first cycle after the close slot.
    // keep leaves word_valid high for a back-to-back offer; tog toggles ack_in in that frame cycle.
    task automatic run_frame(int i, logic [31:0] w, bit keep, int tog);
        int len;
        len = flen(i);
        for (int n = 0; n < 200 && !rdy[i]; n++) @(negedge clk);
        check("ready_before_accept", 32'(rdy[i]), 32'd1);
        wi[i] = w;
        wv[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) wv[i] = 1'b0;
        for (int t = 1; t <= len; t++) begin
            @(negedge clk);
            check("sync", 32'(sy[i]), 32'(m_sync(i, t)));
            check("data", 32'(dat[i]), 32'(m_data(i, t, w)));
            if (t < len) begin
                check("busy_in_frame", 32'(bsy[i]), 32'd1);
                check("done_in_frame", 32'(dn[i]), 32'd0);
            end
            if (t == tog) ack[i] = ~ack[i];
        end
        check("timeout_at_end", 32'(to[i]), 32'd0);
        if (i == 1) begin
            check("busy_ack_wait", 32'(bsy[i]), 32'd1);
            check("ready_ack_wait", 32'(rdy[i]), 32'd0);
            check("done_ack_wait", 32'(dn[i]), 32'd0);
        end else begin
            check("frame_done", 32'(dn[i]), 32'd1);
            check("ready_after", 32'(rdy[i]), 32'd1);
            check("busy_after", 32'(bsy[i]), 32'd0);
        end
    endtask

    task automatic check_all_zero(string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_sync"}, 32'(sy[i]), 32'd0);
            check({tag, "_data"}, 32'(dat[i]), 32'd0);
            check({tag, "_busy"}, 32'(bsy[i]), 32'd0);
            check({tag, "_done"}, 32'(dn[i]), 32'd0);
            check({tag, "_timeout"}, 32'(to[i]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int d;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wv[i] = 1'b0;
            wi[i] = 32'h0;
            ack[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check("ready_after_reset", 32'(rdy[i]), 32'd1);

        // Single frame, then back-to-back frames with no gap
        run_frame(0, 32'h004078F8, 1'b0, 0);
        @(negedge clk);
        check("done_pulse_len", 32'(dn[0]), 32'd0);
        run_frame(0, 32'h80010000, 1'b1, 0);
        run_frame(0, 32'h00005805, 1'b1, 0);
        for (int k = 0; k < 6; k++) run_frame(0, $urandom, (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0, 0);

        // No preamble, short slots
        run_frame(2, 32'h11223344, 1'b0, 0);
        for (int k = 0; k < 6; k++) run_frame(2, $urandom, (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0, 0);

        // Ack wait: a mid-frame ack edge must be ignored, a later one ends the wait 3 cycles on
        for (int k = 0; k < 4; k++) begin
            d = $urandom_range(2, 12);
            run_frame(1, $urandom, 1'b0, (k == 0) ? 10 : $urandom_range(0, flen(1) - 4));
            repeat (d) begin
                @(negedge clk);
                check("ack_wait_hold", 32'(dn[1]), 32'd0);
                check("ack_wait_busy", 32'(bsy[1]), 32'd1);
            end
            ack[1] = ~ack[1];
            repeat (2) begin
                @(negedge clk);
                check("ack_sync_delay", 32'(dn[1]), 32'd0);
            end
            @(negedge clk);
            check("ack_done", 32'(dn[1]), 32'd1);
            check("ack_no_timeout", 32'(to[1]), 32'd0);
            check("ack_ready", 32'(rdy[1]), 32'd1);
            check("ack_idle", 32'(bsy[1]), 32'd0);
        end

        // Timeout 20 cycles after entering the wait
        run_frame(1, $urandom, 1'b0, 0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check("timeout_pulse", 32'(to[1]), 32'(k == 20));
            check("timeout_no_done", 32'(dn[1]), 32'd0);
            if (k == 20) check("timeout_ready", 32'(rdy[1]), 32'd1);
        end

        // Ack seen on the expiry cycle wins over the timeout
        run_frame(1, $urandom, 1'b0, 0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check("tie_done", 32'(dn[1]), 32'(k == 20));
            check("tie_no_timeout", 32'(to[1]), 32'd0);
            if (k == 17) ack[1] = ~ack[1];
        end

        // Asynchronous reset in the middle of the data phase
        for (int n = 0; n < 200 && !rdy[0]; n++) @(negedge clk);
        check("ready_before_reset_frame", 32'(rdy[0]), 32'd1);
        w = $urandom;
        wi[0] = w;
        wv[0] = 1'b1;
        @(posedge clk);
        #1;
        wv[0] = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            check("pre_reset_sync", 32'(sy[0]), 32'(m_sync(0, t)));
            check("pre_reset_data", 32'(dat[0]), 32'(m_data(0, t, w)));
        end
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        rst = 1'b1;
        run_frame(0, $urandom, 1'b0, 0);
        run_frame(2, $urandom, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
